// File: rtl/ram_word_model.sv
// Word-serial main-memory model: writes commit at the sample edge, reads return after a fixed
// pipeline latency with a one-cycle-delayed ack. Optional stats via RAM_WORD_MODEL_STATS_EN.
module ram_word_model #(
  parameter int unsigned ADDR_SIZE = 13,
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned MEM_WORDS = 8192,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 ram_clk,
  input  logic                 ram_rst,
  input  logic                 ram_avalid,
  input  logic                 ram_rnw,
  input  logic [ADDR_SIZE-1:0] ram_addr,
  input  logic [WORD_SIZE-1:0] ram_wdata,
  output logic [WORD_SIZE-1:0] ram_rdata,
`ifdef RAM_WORD_MODEL_STATS_EN
  output logic [31:0]          stat_rd_cnt,
  output logic [31:0]          stat_wr_cnt,
  output logic [15:0]          stat_oor_cnt,
`endif
  output logic                 ram_ack
);

  localparam int unsigned MemAw = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [WORD_SIZE-1:0] mem [MEM_WORDS];

  logic                 req_valid;
  logic                 in_range;
  logic                 rd_en;
  logic                 wr_en;
  logic [MemAw-1:0]     mem_idx;

  logic [WORD_SIZE-1:0] pipe_data_q [LATENCY];
  logic [LATENCY-1:0]   pipe_vld_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 rd_vld_q;
  logic                 ack_q;

  // Compare at 32 bits so MEM_WORDS == 2**ADDR_SIZE does not truncate to zero.
  assign in_range  = 32'(ram_addr) < MEM_WORDS;
  assign req_valid = ram_avalid && !ram_rst;
  assign rd_en     = req_valid && ram_rnw;
  assign wr_en     = req_valid && !ram_rnw && in_range;
  assign mem_idx   = ram_addr[MemAw-1:0];

  // Storage plus read-data shift pipeline; data needs no reset since validity is tracked apart.
  always_ff @(posedge ram_clk) begin
    if (wr_en) begin
      mem[mem_idx] <= ram_wdata;
    end
    if (rd_en) begin
      pipe_data_q[0] <= in_range ? mem[mem_idx] : '0;
    end
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= rd_en;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  // Data lands at T+LATENCY; ack trails by one cycle for the consumer's data register.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      rdata_q  <= '0;
      rd_vld_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      rd_vld_q <= pipe_vld_q[LATENCY-1];
      ack_q    <= rd_vld_q;
      if (pipe_vld_q[LATENCY-1]) begin
        rdata_q <= pipe_data_q[LATENCY-1];
      end
    end
  end

  assign ram_rdata = rdata_q;
  assign ram_ack   = ack_q;

`ifdef RAM_WORD_MODEL_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [15:0] oor_cnt_q;

  // Saturating counters, updated at the request sample edge.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      oor_cnt_q <= '0;
    end else begin
      if (rd_en && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (wr_en && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
      if (req_valid && !in_range && (oor_cnt_q != '1)) begin
        oor_cnt_q <= oor_cnt_q + 16'd1;
      end
    end
  end

  assign stat_rd_cnt  = rd_cnt_q;
  assign stat_wr_cnt  = wr_cnt_q;
  assign stat_oor_cnt = oor_cnt_q;
`endif

endmodule

// File: tb/tb_ram_word_model.sv
// Scoreboard bench for ram_word_model: the driver queues expected read words, the monitor
// checks each ack against the word presented the cycle before and against the ack latency.
module tb_ram_word_model;
  localparam int AW  = 13;
  localparam int WW  = 16;
  localparam int MW  = 4096;
  localparam int LAT = 4;

  logic          ram_clk = 1'b0;
  logic          ram_rst;
  logic          ram_avalid;
  logic          ram_rnw;
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_wdata;
  logic [WW-1:0] ram_rdata;
  logic          ram_ack;
`ifdef RAM_WORD_MODEL_STATS_EN
  logic [31:0]   stat_rd_cnt;
  logic [31:0]   stat_wr_cnt;
  logic [15:0]   stat_oor_cnt;
`endif

  always #5 ram_clk = ~ram_clk;

  ram_word_model #(
    .ADDR_SIZE (AW),
    .WORD_SIZE (WW),
    .MEM_WORDS (MW),
    .LATENCY   (LAT)
  ) dut (
    .ram_clk      (ram_clk),
    .ram_rst      (ram_rst),
    .ram_avalid   (ram_avalid),
    .ram_rnw      (ram_rnw),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
`ifdef RAM_WORD_MODEL_STATS_EN
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_oor_cnt (stat_oor_cnt),
`endif
    .ram_ack      (ram_ack)
  );

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int ack_cnt = 0;
  logic [WW-1:0] exp_q [$];
  int            iss_q [$];
  logic [WW-1:0] prev_rdata = '0;
  logic [WW-1:0] mon_exp;
  int            mon_iss;

  always @(posedge ram_clk) edge_no <= edge_no + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: an ack pushes the word that was on ram_rdata during the previous cycle.
  always @(negedge ram_clk) begin
    if (ram_ack === 1'b1) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack at edge %0d: got ack=1 expected ack=0", edge_no);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_iss = iss_q.pop_front();
        check("ack_data", 32'(prev_rdata), 32'(mon_exp));
        check("ack_latency", 32'(edge_no - mon_iss), 32'(LAT + 1));
      end
    end
    prev_rdata = ram_rdata;
  end

  task automatic req(input logic rnw, input logic [AW-1:0] a, input logic [WW-1:0] d,
                     input logic [WW-1:0] exp, input bit push);
    ram_avalid = 1'b1;
    ram_rnw    = rnw;
    ram_addr   = a;
    ram_wdata  = d;
    if (rnw && push) begin
      exp_q.push_back(exp);
      iss_q.push_back(edge_no + 1);
    end
    @(negedge ram_clk);
    ram_avalid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] d);
    req(1'b0, a, d, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [WW-1:0] exp);
    req(1'b1, a, '0, exp, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ram_clk);
  endtask

  int c0;
  int waited;

  initial begin
    ram_rst    = 1'b1;
    ram_avalid = 1'b0;
    ram_rnw    = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    repeat (2) @(negedge ram_clk);
    check("reset_ack", 32'(ram_ack), 32'd0);
    check("reset_rdata", 32'(ram_rdata), 32'd0);
    ram_rst = 1'b0;
    idle(1);

    // Write then read
    c0 = ack_cnt;
    wr(13'h0010, 16'hBEEF);
    rd(13'h0010, 16'hBEEF);
    idle(LAT + 4);
    check("single_read_ack_count", 32'(ack_cnt - c0), 32'd1);

    // Burst of four reads
    wr(13'h0100, 16'h1111);
    wr(13'h0101, 16'h2222);
    wr(13'h0102, 16'h3333);
    wr(13'h0103, 16'h4444);
    c0 = ack_cnt;
    for (int i = 0; i < 4; i++) begin
      logic [WW-1:0] w;
      w = 16'h1111 * WW'(i + 1);
      rd(13'h0100 + AW'(i), w);
    end
    idle(LAT + 4);
    check("burst_ack_count", 32'(ack_cnt - c0), 32'd4);

    // Snapshot: a later write must not disturb an in-flight read
    wr(13'h0020, 16'h00AA);
    rd(13'h0020, 16'h00AA);
    wr(13'h0020, 16'h00BB);
    idle(2);
    rd(13'h0020, 16'h00BB);
    idle(LAT + 4);

    // Writes are silent
    c0 = ack_cnt;
    for (int i = 0; i < 8; i++) wr(13'h0200 + AW'(i), 16'hA000 + WW'(i));
    idle(LAT + 4);
    check("writes_silent", 32'(ack_cnt - c0), 32'd0);
    rd(13'h0205, 16'hA005);
    idle(LAT + 4);

    // Reset mid-flight; the write presented during reset must be ignored
    wr(13'h0030, 16'h1234);
    idle(2);
    c0 = ack_cnt;
    req(1'b1, 13'h0010, '0, '0, 1'b0);
    req(1'b1, 13'h0020, '0, '0, 1'b0);
    ram_rst    = 1'b1;
    ram_avalid = 1'b1;
    ram_rnw    = 1'b0;
    ram_addr   = 13'h0030;
    ram_wdata  = 16'hDEAD;
    @(negedge ram_clk);
    ram_rst    = 1'b0;
    ram_avalid = 1'b0;
    idle(LAT + 4);
    check("reset_midflight_no_ack", 32'(ack_cnt - c0), 32'd0);
    check("reset_midflight_rdata", 32'(ram_rdata), 32'd0);

    // Out of range with MEM_WORDS=4096
    c0 = ack_cnt;
    wr(13'h1800, 16'h5555);
    rd(13'h1800, 16'h0000);
    idle(LAT + 4);
    check("oor_read_acked", 32'(ack_cnt - c0), 32'd1);
`ifdef RAM_WORD_MODEL_STATS_EN
    check("stat_oor_cnt", 32'(stat_oor_cnt), 32'd2);
    check("stat_rd_cnt", stat_rd_cnt, 32'd1);
    check("stat_wr_cnt", stat_wr_cnt, 32'd0);
`endif

    // Memory survives reset
    rd(13'h0030, 16'h1234);
    rd(13'h0010, 16'hBEEF);
    idle(LAT + 4);
`ifdef RAM_WORD_MODEL_STATS_EN
    check("stat_rd_cnt_final", stat_rd_cnt, 32'd3);
`endif

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge ram_clk);
      waited++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
